// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-port RAM arbiter:
//               FSM state encoding, port index constants and the default
//               address limit.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // Arbiter FSM: IDLE accepts a request, ISSUE drives the RAM for one cycle,
  // RESP captures the RAM result for one cycle and raises the port ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Port indices as carried on the grant signal.
  localparam logic PORT_IF  = 1'b0;  // instruction fetch (port 0)
  localparam logic PORT_MEM = 1'b1;  // load/store       (port 1)

  // First illegal byte address unless overridden on the top module.
  localparam int unsigned ADDR_LIMIT_DEFAULT = 1024;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester ports and the RAM-side bus of the
//               arbiter.
//               Port 0 (fetch) : p0_req, p0_addr -> p0_ack, p0_rdata, p0_err
//               Port 1 (ld/st) : p1_req, p1_we, p1_addr, p1_wdata
//                                -> p1_ack, p1_rdata, p1_err
//               RAM side       : ram_address, ram_data_write, ram_write_en,
//                                ram_read_en -> ; <- ram_data_out
//               modport slave  : the arbiter view
//               modport master : the view of whatever surrounds the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;

  // Port 0: instruction fetch (read only)
  logic        p0_req;
  logic [31:0] p0_addr;
  logic        p0_ack;
  logic [31:0] p0_rdata;
  logic        p0_err;

  // Port 1: load/store
  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;
  logic        p1_err;

  // RAM side
  logic [31:0] ram_address;
  logic [31:0] ram_data_write;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [31:0] ram_data_out;

  modport slave (
    input  p0_req, p0_addr,
    output p0_ack, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata, p1_err,
    output ram_address, ram_data_write, ram_write_en, ram_read_en,
    input  ram_data_out
  );

  modport master (
    output p0_req, p0_addr,
    input  p0_ack, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata, p1_err,
    input  ram_address, ram_data_write, ram_write_en, ram_read_en,
    output ram_data_out
  );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin picker. When both requests
//               are present the port that was not granted last wins;
//               otherwise the single requester wins.
//               req[1:0] in  : request per port (bit index = port index)
//               last     in  : port index granted most recently
//               grant    out : chosen port index (meaningful when valid=1)
//               valid    out : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_IF;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = PORT_MEM;
    end else begin
      grant = PORT_IF;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Arbitrates a fetch port and a load/store port onto a single
//               synchronous RAM. One access takes three cycles
//               (IDLE -> ISSUE -> RESP); addresses at or above ADDR_LIMIT
//               complete with err=1 and never touch the RAM.
//               clk   in : single clock, rising edge
//               rst_n in : asynchronous active-low reset
//               bus       : ram_arbiter_if.slave (both ports + RAM bus)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
)(
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam logic [31:0] C_ADDR_LIMIT = 32'(ADDR_LIMIT);

  state_t      r_state;
  state_t      w_next_state;

  // Access latched in IDLE and used through ISSUE/RESP
  logic        r_grant;
  logic        r_last_grant;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_err;

  // Registered port outputs
  logic        r_p0_ack;
  logic [31:0] r_p0_rdata;
  logic        r_p0_err;
  logic        r_p1_ack;
  logic [31:0] r_p1_rdata;
  logic        r_p1_err;

  // Combinational RAM-side outputs and control
  logic [1:0]  w_req;
  logic        w_grant;
  logic        w_valid;
  logic        w_load;
  logic        w_in_range;
  logic [31:0] w_ram_address;
  logic [31:0] w_ram_data_write;
  logic        w_ram_write_en;
  logic        w_ram_read_en;

  // A port whose ack is high this cycle still has its old request asserted;
  // masking it prevents a second service of the same request.
  assign w_req = {bus.p1_req & ~r_p1_ack, bus.p0_req & ~r_p0_ack};

  assign w_in_range = (r_addr < C_ADDR_LIMIT);

  rr_arbiter2 u_rr_arbiter2 (
    .req   (w_req),
    .last  (r_last_grant),
    .grant (w_grant),
    .valid (w_valid)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and RAM-side outputs. RAM outputs are decoded from the
  // state so that reset clears the strobes without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state     = r_state;
    w_load           = 1'b0;
    w_ram_address    = 32'd0;
    w_ram_data_write = 32'd0;
    w_ram_write_en   = 1'b0;
    w_ram_read_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_load       = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        // Out-of-range accesses leave the RAM bus entirely quiet.
        if (w_in_range) begin
          w_ram_address    = r_addr;
          w_ram_data_write = r_wdata;
          w_ram_write_en   = r_we;
          w_ram_read_en    = ~r_we;
        end
        w_next_state = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, error capture and port responses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= PORT_IF;
      r_last_grant <= PORT_MEM;   // port 0 wins the first tie
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_p0_ack     <= 1'b0;
      r_p0_rdata   <= 32'd0;
      r_p0_err     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p1_rdata   <= 32'd0;
      r_p1_err     <= 1'b0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;

      if (w_load) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        if (w_grant == PORT_MEM) begin
          r_addr  <= bus.p1_addr;
          r_wdata <= bus.p1_wdata;
          r_we    <= bus.p1_we;
        end else begin
          r_addr  <= bus.p0_addr;
          r_wdata <= 32'd0;
          r_we    <= 1'b0;
        end
      end

      if (r_state == ISSUE) begin
        r_err <= ~w_in_range;
      end

      if (r_state == RESP) begin
        if (r_grant == PORT_IF) begin
          r_p0_ack   <= 1'b1;
          r_p0_err   <= r_err;
          r_p0_rdata <= r_err ? 32'd0 : bus.ram_data_out;
        end else begin
          r_p1_ack <= 1'b1;
          r_p1_err <= r_err;
          // Stores leave the previous load data visible.
          if (!r_we) begin
            r_p1_rdata <= r_err ? 32'd0 : bus.ram_data_out;
          end
        end
      end
    end
  end

  assign bus.p0_ack         = r_p0_ack;
  assign bus.p0_rdata       = r_p0_rdata;
  assign bus.p0_err         = r_p0_err;
  assign bus.p1_ack         = r_p1_ack;
  assign bus.p1_rdata       = r_p1_rdata;
  assign bus.p1_err         = r_p1_err;
  assign bus.ram_address    = w_ram_address;
  assign bus.ram_data_write = w_ram_data_write;
  assign bus.ram_write_en   = w_ram_write_en;
  assign bus.ram_read_en    = w_ram_read_en;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. A behavioural RAM sits on
//               the RAM bus; expected port responses are queued per port when
//               a request is driven and compared when the matching ack fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned C_LIMIT = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int checks   = 0;
  int failures = 0;

  int rd_pulses = 0;
  int wr_pulses = 0;
  int ack_total = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];

  logic [31:0] ram_mem [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_p1_last;

  ram_arbiter_if bus ();

  ram_arbiter #(.ADDR_LIMIT(C_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.ram_write_en) ram_mem[bus.ram_address[9:2]] <= bus.ram_data_write;
    if (bus.ram_read_en)  bus.ram_data_out <= ram_mem[bus.ram_address[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Expected-result generators
  task automatic push0(input logic [31:0] addr);
    exp_t e;
    e.err   = (addr >= C_LIMIT);
    e.rdata = e.err ? 32'd0 : exp_mem[addr[9:2]];
    q0.push_back(e);
  endtask

  task automatic push1(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.err = (addr >= C_LIMIT);
    if (we) begin
      if (!e.err) exp_mem[addr[9:2]] = wdata;
      e.rdata = exp_p1_last;
    end else begin
      e.rdata     = e.err ? 32'd0 : exp_mem[addr[9:2]];
      exp_p1_last = e.rdata;
    end
    q1.push_back(e);
  endtask

  // Monitor: protocol rules and scoreboard compare, sampled mid-cycle
  initial begin : monitor
    logic prev_re, prev_we, prev_a0, prev_a1;
    exp_t e;
    prev_re = 0; prev_we = 0; prev_a0 = 0; prev_a1 = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ram_read_en | bus.ram_write_en)
          check("strobe_excl", 32'(bus.ram_read_en & bus.ram_write_en), 0);
        else
          check("ram_quiet", bus.ram_address | bus.ram_data_write, 0);
        if (bus.ram_read_en) begin rd_pulses++; check("re_width", 32'(prev_re), 0); end
        if (bus.ram_write_en) begin wr_pulses++; check("we_width", 32'(prev_we), 0); end
        if (bus.p0_ack | bus.p1_ack) begin
          ack_total++;
          check("dual_ack", 32'(bus.p0_ack & bus.p1_ack), 0);
        end
        if (bus.p0_ack) begin
          grant_log.push_back(0);
          check("p0_ack_width", 32'(prev_a0), 0);
          check("p0_unexp_ack", 32'(q0.size() == 0), 0);
          if (q0.size() != 0) begin
            e = q0.pop_front();
            check("p0_rdata", bus.p0_rdata, e.rdata);
            check("p0_err", 32'(bus.p0_err), 32'(e.err));
          end
        end
        if (bus.p1_ack) begin
          grant_log.push_back(1);
          check("p1_ack_width", 32'(prev_a1), 0);
          check("p1_unexp_ack", 32'(q1.size() == 0), 0);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            check("p1_rdata", bus.p1_rdata, e.rdata);
            check("p1_err", 32'(bus.p1_err), 32'(e.err));
          end
        end
      end
      prev_re = bus.ram_read_en;
      prev_we = bus.ram_write_en;
      prev_a0 = bus.p0_ack;
      prev_a1 = bus.p1_ack;
    end
  end

  // Drivers: request on a negedge, hold until ack, optionally one cycle longer.
  task automatic do_p0(input logic [31:0] addr, input bit hold_extra, output int lat);
    int t0, n;
    @(negedge clk);
    bus.p0_addr = addr;
    bus.p0_req  = 1'b1;
    push0(addr);
    t0 = cyc;
    n  = 0;
    while (!bus.p0_ack && n < 30) begin @(negedge clk); n++; end
    check("p0_timeout", 32'(n >= 30), 0);
    lat = cyc - t0;
    if (hold_extra) @(negedge clk);
    bus.p0_req = 1'b0;
  endtask

  task automatic do_p1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    int t0, n;
    @(negedge clk);
    bus.p1_we    = we;
    bus.p1_addr  = addr;
    bus.p1_wdata = wdata;
    bus.p1_req   = 1'b1;
    push1(we, addr, wdata);
    t0 = cyc;
    n  = 0;
    while (!bus.p1_ack && n < 30) begin @(negedge clk); n++; end
    check("p1_timeout", 32'(n >= 30), 0);
    lat = cyc - t0;
    bus.p1_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, lat1, r0, w0, a0, a1, acks0, n;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'(i * 4);
      exp_mem[i] = 32'(i * 4);
    end
    exp_p1_last      = 32'd0;
    bus.p0_req       = 0; bus.p0_addr = 0;
    bus.p1_req       = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
    bus.ram_data_out = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_acks", {30'd0, bus.p0_ack, bus.p1_ack}, 0);
    check("rst_errs", {30'd0, bus.p0_err, bus.p1_err}, 0);
    check("rst_rdata", bus.p0_rdata | bus.p1_rdata, 0);
    check("rst_strobes", {30'd0, bus.ram_read_en, bus.ram_write_en}, 0);
    check("rst_ram_addr", bus.ram_address, 0);
    rst_n = 1'b1;

    // Single fetch: latency and one read strobe
    r0 = rd_pulses;
    do_p0(32'h8, 0, lat);
    check("p0_latency", 32'(lat), 3);
    check("p0_read_pulses", 32'(rd_pulses - r0), 1);

    // Store then load on port 1
    w0 = wr_pulses;
    do_p1(1, 32'h10, 32'h55, lat);
    check("p1_store_latency", 32'(lat), 3);
    check("p1_write_pulses", 32'(wr_pulses - w0), 1);
    do_p1(0, 32'h10, 0, lat);
    check("p1_load_latency", 32'(lat), 3);

    // Boundaries: last legal byte, first illegal store
    do_p0(C_LIMIT - 1, 0, lat);
    w0 = wr_pulses;
    do_p1(1, C_LIMIT, 32'hDEAD, lat);
    check("err_store_latency", 32'(lat), 3);
    check("err_store_no_write", 32'(wr_pulses - w0), 0);
    do_p1(0, 32'h3FC, 0, lat);

    // Concurrent: out-of-range load on port 1, legal fetch on port 0
    r0 = rd_pulses; w0 = wr_pulses;
    fork
      do_p1(0, 32'h400, 0, lat1);
      do_p0(32'h3FC, 0, lat);
    join
    check("mix_read_pulses", 32'(rd_pulses - r0), 1);
    check("mix_write_pulses", 32'(wr_pulses - w0), 0);

    // Fetch request held through its ack cycle: exactly one access
    r0 = rd_pulses; acks0 = ack_total;
    do_p0(32'h4, 1, lat);
    repeat (6) @(negedge clk);
    check("hold_read_pulses", 32'(rd_pulses - r0), 1);
    check("hold_acks", 32'(ack_total - acks0), 1);

    // Both ports requesting continuously from reset: strict alternation
    @(negedge clk);
    rst_n = 1'b0;
    exp_p1_last = 32'd0;
    bus.p0_addr = 32'h0C; bus.p0_req = 1'b1;
    bus.p1_we = 1'b0; bus.p1_addr = 32'h14; bus.p1_req = 1'b1;
    push0(32'h0C); push0(32'h0C);
    push1(0, 32'h14, 0); push1(0, 32'h14, 0);
    grant_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 40 && (a0 < 2 || a1 < 2); i++) begin
      @(negedge clk);
      if (bus.p0_ack) begin a0++; if (a0 == 2) bus.p0_req = 1'b0; end
      if (bus.p1_ack) begin a1++; if (a1 == 2) bus.p1_req = 1'b0; end
    end
    repeat (4) @(negedge clk);
    check("rr_log_size", 32'(grant_log.size()), 4);
    if (grant_log.size() >= 4) begin
      check("rr_grant0", 32'(grant_log[0]), 0);
      check("rr_grant1", 32'(grant_log[1]), 1);
      check("rr_grant2", 32'(grant_log[2]), 0);
      check("rr_grant3", 32'(grant_log[3]), 1);
    end

    // Reset during the ISSUE cycle of a store
    @(negedge clk);
    bus.p1_we = 1'b1; bus.p1_addr = 32'h20; bus.p1_wdata = 32'h77; bus.p1_req = 1'b1;
    n = 0;
    while (!bus.ram_write_en && n < 10) begin @(negedge clk); n++; end
    check("abort_reached_issue", 32'(n >= 10), 0);
    rst_n = 1'b0;
    #1;
    check("abort_we_drop", 32'(bus.ram_write_en), 0);
    check("abort_state_idle", 32'(dut.r_state), 32'(IDLE));
    check("abort_p1_ack", 32'(bus.p1_ack), 0);
    check("abort_p1_rdata", bus.p1_rdata, 0);
    exp_p1_last = 32'd0;
    @(negedge clk);
    bus.p1_req = 1'b0;
    @(negedge clk);
    acks0 = ack_total;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_ack", 32'(ack_total - acks0), 0);
    // The abandoned store must not have reached the RAM.
    do_p1(0, 32'h20, 0, lat);

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
